// File: rtl/sample_resize_if.sv
// Streaming handshake bundle for sample_resize: input sample side and resized output side.
interface sample_resize_if #(
    parameter int LENGTH_IN  = 16,
    parameter int LENGTH_OUT = 20
);
    logic signed [LENGTH_IN-1:0]  in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [LENGTH_OUT-1:0] out_data;
    logic                         out_sat;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/sample_resize.sv
// Two-stage signed sample resizer: optional LSB drop with rounding, then extend/saturate/wrap.
// Defining SAMPLE_RESIZE_SAT_COUNT_EN adds a 16-bit saturating count of clamped output transfers.
module sample_resize #(
    parameter int LENGTH_IN  = 16,
    parameter int LENGTH_OUT = 20,
    parameter int DROP_LSB   = 0,
    parameter int ROUND      = 1,
    parameter int SATURATE   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sample_resize_if.slave bus
`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
    ,
    output logic [15:0]    sat_count
`endif
);

    // One guard bit above the input keeps +max plus the rounding constant from overflowing.
    localparam int W = LENGTH_IN + 1 - DROP_LSB;
    localparam logic signed [LENGTH_IN:0] RND_ADD =
        (LENGTH_IN+1)'((ROUND != 0 && DROP_LSB > 0) ? 1 : 0) << ((DROP_LSB > 0) ? DROP_LSB - 1 : 0);

    function automatic logic signed [W-1:0] round_shift(input logic signed [LENGTH_IN-1:0] x);
        logic signed [LENGTH_IN:0] sum;
        sum = (LENGTH_IN+1)'(x) + RND_ADD;
        return W'(sum >>> DROP_LSB);
    endfunction

    logic                         vld_p1;
    logic                         vld_p2;
    logic signed [W-1:0]          data_p1;
    logic signed [LENGTH_OUT-1:0] data_p2;
    logic                         sat_p2;
    logic signed [LENGTH_OUT-1:0] fit_data;
    logic                         fit_sat;
    logic                         load_p1;
    logic                         load_p2;

    assign load_p2      = !vld_p2 || bus.out_ready;
    assign load_p1      = !vld_p1 || load_p2;
    assign bus.in_ready = load_p1;

    generate
        if (W <= LENGTH_OUT) begin : g_extend
            always_comb begin
                fit_data = LENGTH_OUT'(data_p1);
                fit_sat  = 1'b0;
            end
        end else begin : g_fit
            localparam logic signed [LENGTH_OUT-1:0] MAX_OUT = {1'b0, {(LENGTH_OUT-1){1'b1}}};
            localparam logic signed [LENGTH_OUT-1:0] MIN_OUT = {1'b1, {(LENGTH_OUT-1){1'b0}}};

            // Overflow whenever the bits above the output sign bit disagree with it.
            function automatic logic [LENGTH_OUT:0] saturate(input logic signed [W-1:0] x);
                logic [W-LENGTH_OUT:0] top;
                logic                  ovf;
                top = x[W-1:LENGTH_OUT-1];
                ovf = (top != '0) && (top != '1);
                if (ovf && SATURATE != 0)
                    return {1'b1, x[W-1] ? MIN_OUT : MAX_OUT};
                return {1'b0, x[LENGTH_OUT-1:0]};
            endfunction

            always_comb begin
                {fit_sat, fit_data} = saturate(data_p1);
            end
        end
    endgenerate

    // Stage 1: round and drop LSBs
    always_ff @(posedge clk) begin
        if (load_p1 && bus.in_valid)
            data_p1 <= round_shift(bus.in_data);
    end

    // Stage 2: fit to output width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            sat_p2  <= 1'b0;
        end else begin
            if (load_p1)
                vld_p1 <= bus.in_valid;
            if (load_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    data_p2 <= fit_data;
                    sat_p2  <= fit_sat;
                end
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_data  = data_p2;
    assign bus.out_sat   = sat_p2;

`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (vld_p2 && bus.out_ready && sat_p2 && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sample_resize.sv
// Scoreboard bench for sample_resize across four configurations (extend, round+sat, wrap, truncate).
module tb_sample_resize;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        sat;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [3:0]  iv, ir, ov, os, ordy, ordy_man;
    logic        rnd_on, rnd_bit;
    logic [15:0] idat[4];
    logic [31:0] odr[4];
    logic [15:0] sat_cnt[4];

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign ordy[0] = rnd_on ? rnd_bit : ordy_man[0];
    assign ordy[1] = rnd_on ? rnd_bit : ordy_man[1];
    assign ordy[2] = rnd_on ? rnd_bit : ordy_man[2];
    assign ordy[3] = rnd_on ? rnd_bit : ordy_man[3];

    sample_resize_if #(.LENGTH_IN(16), .LENGTH_OUT(20)) if_a ();
    sample_resize_if #(.LENGTH_IN(16), .LENGTH_OUT(12)) if_b ();
    sample_resize_if #(.LENGTH_IN(16), .LENGTH_OUT(12)) if_c ();
    sample_resize_if #(.LENGTH_IN(16), .LENGTH_OUT(12)) if_d ();

    assign if_a.in_data = idat[0];  assign if_a.in_valid = iv[0];  assign if_a.out_ready = ordy[0];
    assign if_b.in_data = idat[1];  assign if_b.in_valid = iv[1];  assign if_b.out_ready = ordy[1];
    assign if_c.in_data = idat[2];  assign if_c.in_valid = iv[2];  assign if_c.out_ready = ordy[2];
    assign if_d.in_data = idat[3];  assign if_d.in_valid = iv[3];  assign if_d.out_ready = ordy[3];
    assign ir[0] = if_a.in_ready;  assign ov[0] = if_a.out_valid;  assign os[0] = if_a.out_sat;
    assign ir[1] = if_b.in_ready;  assign ov[1] = if_b.out_valid;  assign os[1] = if_b.out_sat;
    assign ir[2] = if_c.in_ready;  assign ov[2] = if_c.out_valid;  assign os[2] = if_c.out_sat;
    assign ir[3] = if_d.in_ready;  assign ov[3] = if_d.out_valid;  assign os[3] = if_d.out_sat;
    assign odr[0] = {12'b0, if_a.out_data};
    assign odr[1] = {20'b0, if_b.out_data};
    assign odr[2] = {20'b0, if_c.out_data};
    assign odr[3] = {20'b0, if_d.out_data};

`ifndef SAMPLE_RESIZE_SAT_COUNT_EN
    assign sat_cnt[0] = '0;
    assign sat_cnt[1] = '0;
    assign sat_cnt[2] = '0;
    assign sat_cnt[3] = '0;
`endif

    sample_resize #(.LENGTH_IN(16), .LENGTH_OUT(20), .DROP_LSB(0), .ROUND(1), .SATURATE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
        , .sat_count(sat_cnt[0])
`endif
    );
    sample_resize #(.LENGTH_IN(16), .LENGTH_OUT(12), .DROP_LSB(4), .ROUND(1), .SATURATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
        , .sat_count(sat_cnt[1])
`endif
    );
    sample_resize #(.LENGTH_IN(16), .LENGTH_OUT(12), .DROP_LSB(4), .ROUND(1), .SATURATE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave)
`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
        , .sat_count(sat_cnt[2])
`endif
    );
    sample_resize #(.LENGTH_IN(16), .LENGTH_OUT(12), .DROP_LSB(4), .ROUND(0), .SATURATE(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .bus(if_d.slave)
`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
        , .sat_count(sat_cnt[3])
`endif
    );

    // Reference: exact integer arithmetic with floor division and range-based fitting.
    function automatic logic [32:0] model(input int d, input logic [15:0] x);
        int     lo, drop;
        bit     rnd, satm;
        longint v, p, mx, mn;
        logic   s;
        lo   = (d == 0) ? 20 : 12;
        drop = (d == 0) ? 0 : 4;
        rnd  = (d != 3);
        satm = (d != 2);
        v    = longint'($signed(x));
        p    = longint'(1) << drop;
        if (rnd && drop > 0) v = v + p / 2;
        v  = (v >= 0) ? v / p : -((-v + p - 1) / p);
        mx = (longint'(1) << (lo - 1)) - 1;
        mn = -mx - 1;
        s  = 1'b0;
        if ((v > mx || v < mn) && satm) begin
            v = (v > mx) ? mx : mn;
            s = 1'b1;
        end
        return {s, 32'(v & ((longint'(1) << lo) - 1))};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 4; d++) begin
                if (ov[d] && ordy[d]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL sb_unexpected dut=%0d observed=%0h expected=none", d, odr[d]);
                    end else begin
                        e = sb.pop_front();
                        check("sb_dut", 64'(d), 64'(e.dut));
                        check("sb_data", 64'(odr[d]), 64'(e.data));
                        check("sb_sat", 64'(os[d]), 64'(e.sat));
                        if (e.due >= 0) check("sb_latency", 64'(cyc), 64'(e.due));
                    end
                end
            end
        end
    end

    // Call aligned at posedge+1; returns aligned at posedge+1 after the input transfer.
    task automatic send(input int d, input logic [15:0] x, input logic [32:0] e, input bit lat);
        bit   done;
        exp_t item;
        done    = 1'b0;
        iv[d]   = 1'b1;
        idat[d] = x;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ir[d]) begin
                item.dut  = d;
                item.data = e[31:0];
                item.sat  = e[32];
                item.due  = lat ? cyc + 2 : -1;
                sb.push_back(item);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        iv[d] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL send_timeout dut=%0d observed=no_accept expected=accept", d);
        end
    endtask

    task automatic sendm(input int d, input logic [15:0] x, input bit lat);
        send(d, x, model(d, x), lat);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] corners[8] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF,
                                16'h7FF8, 16'h7FF7, 16'h0008, 16'hFFF8};

    initial begin
        rst_n    = 1'b0;
        iv       = '0;
        ordy_man = '1;
        rnd_on   = 1'b0;
        for (int d = 0; d < 4; d++) idat[d] = '0;

        #2;
        for (int d = 0; d < 4; d++) begin
            check("rst_valid", 64'(ov[d]), 64'd0);
            check("rst_data", 64'(odr[d]), 64'd0);
            check("rst_sat", 64'(os[d]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("idle_in_ready", 64'(ir[0]), 64'd1);

        // Sign extension, back-to-back with fixed latency
        send(0, 16'h8000, {1'b0, 32'hF8000}, 1'b1);
        send(0, 16'h7FFF, {1'b0, 32'h07FFF}, 1'b1);
        send(0, 16'h0001, {1'b0, 32'h00001}, 1'b1);
        wait_drain();

        // Round + saturate; -32760/16 floors to -2048, which still fits
        send(1, 16'h0018, {1'b0, 32'h002}, 1'b1);
        send(1, 16'hFFE8, {1'b0, 32'hFFF}, 1'b1);
        send(1, 16'h7FFF, {1'b1, 32'h7FF}, 1'b1);
        send(1, 16'h8000, {1'b0, 32'h800}, 1'b1);
        wait_drain();

        // Wrap and truncate variants
        send(2, 16'h7FFF, {1'b0, 32'h800}, 1'b1);
        wait_drain();
        send(3, 16'h0018, {1'b0, 32'h001}, 1'b1);
        send(3, 16'hFFE8, {1'b0, 32'hFFE}, 1'b1);
        wait_drain();

        // Corner values then random samples under random out_ready
        rnd_on = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 8; k++) sendm(d, corners[k], 1'b0);
            for (int k = 0; k < 12; k++) sendm(d, 16'($urandom), 1'b0);
            wait_drain();
        end
        rnd_on = 1'b0;

        // Backpressure: two accepted, third stalls, all emerge in order
        ordy_man[0] = 1'b0;
        sendm(0, 16'h0111, 1'b0);
        sendm(0, 16'h0222, 1'b0);
        iv[0]   = 1'b1;
        idat[0] = 16'h0333;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(ov[0]), 64'd1);
            check("bp_in_ready", 64'(ir[0]), 64'd0);
            check("bp_hold", 64'(odr[0]), 64'h00111);
        end
        @(posedge clk);
        #1;
        ordy_man[0] = 1'b1;
        sendm(0, 16'h0333, 1'b0);
        wait_drain();

        // Asynchronous reset with both stages full
        ordy_man[0] = 1'b0;
        sendm(0, 16'h0444, 1'b0);
        sendm(0, 16'h0555, 1'b0);
        @(negedge clk);
        check("full_valid", 64'(ov[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(ov[0]), 64'd0);
        check("arst_data", 64'(odr[0]), 64'd0);
        check("arst_in_ready", 64'(ir[0]), 64'd1);
        sb.delete();
`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
        check("arst_sat_count", 64'(sat_cnt[1]), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        ordy_man[0] = 1'b1;
        send(0, 16'h0666, {1'b0, 32'h00666}, 1'b1);
        wait_drain();

`ifdef SAMPLE_RESIZE_SAT_COUNT_EN
        // Saturation count: a held output counts once
        sendm(1, 16'h7FFF, 1'b0);
        sendm(1, 16'h7FF8, 1'b0);
        sendm(1, 16'h7FF9, 1'b0);
        ordy_man[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ordy_man[1] = 1'b1;
        sendm(1, 16'h7FFA, 1'b0);
        sendm(1, 16'h7FFB, 1'b0);
        wait_drain();
        check("sat_count", 64'(sat_cnt[1]), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
